// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encodings and owner IDs.
package mem_port_arbiter_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // A transaction ends on memory ready or when the wait budget is exhausted.
  function automatic logic txn_ends(input logic ready, input logic [7:0] cnt,
                                    input logic [7:0] max_wait);
    return ready || (cnt == max_wait);
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and DM requests.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise DM has fixed priority.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic any_req,
  output logic winner
);

  assign any_req = if_req | dm_req;

  always_comb begin
    winner = OWN_IF;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
      winner = ~last_owner;
`else
      winner = OWN_DM;
`endif
    end else if (dm_req) begin
      winner = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with a wait timeout.
// Build option MEM_ARB_RR_EN enables round-robin arbitration (default: DM beats IF).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          sel,
  output logic          if_done,
  output logic          dm_done,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

  logic [0:0]    state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          sel_q, sel_d;

  logic any_req;
  logic winner;
  logic busy;
  logic fin;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  assign busy = (state_q == ST_BUSY);
  assign fin  = busy && txn_ends(mem_ready, wait_cnt_q, MAX_W);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    if (!busy) begin
      if (any_req) begin
        state_d    = ST_BUSY;
        wait_cnt_d = '0;
        mem_req_d  = 1'b1;
        sel_d      = winner;
        mem_we_d   = (winner == OWN_DM) && dm_we;
        addr_d     = (winner == OWN_DM) ? dm_addr : if_addr;
        wdata_d    = (winner == OWN_DM) ? dm_wdata : '0;
`ifdef MEM_ARB_RR_EN
        last_owner_d = winner;
`endif
      end
    end else if (fin) begin
      // Address and owner stay latched; only the strobes drop on completion.
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= OWN_IF;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_DM;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign sel       = sel_q;
  assign if_done   = fin && (sel_q == OWN_IF);
  assign dm_done   = fin && (sel_q == OWN_DM);
  assign err       = fin && !mem_ready;
  assign rdata     = mem_rdata;

endmodule
